lsu_ctrl: RTL and testbench

Load/store sequencer between the single-cycle core datapath and a handshaked data memory port. It consumes the decoder's memory control fields (mem_byt_en, mem_wr_en, sel_dmem_wb, sign_ext) and the ALU address. It runs a req/gnt/rvalid transaction, stalls the core until the access completes, and returns aligned, extended load data for writeback. It also flags misaligned accesses.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/lsu_ctrl_load_align.sv | 27 ++
 rtl/lsu_ctrl.sv | 143 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core types: load/store sequencer states, access-size byte enables
// and the alignment rule used when a memory access is launched.
package cpu_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_DONE
    } t_lsu_state;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Bytes are always legal, halves need an even address, words need 4-byte
    // alignment. Any other size encoding is rejected as misaligned.
    function automatic logic lsu_aligned(input logic [3:0] be, input logic [1:0] offset);
        case (be)
            BE_BYTE: return 1'b1;
            BE_HALF: return ~offset[0];
            BE_WORD: return offset == 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_load_align.sv
// Load-return alignment: moves the addressed lanes of a memory word down to
// bit 0, then zero- or sign-extends them according to the access size.
module lsu_load_align
    import cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [3:0]  be,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [31:0] shifted;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        data    = shifted;
        case (be)
            BE_BYTE: data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            BE_HALF: data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the core and a req/gnt/rvalid data port.
// Build option: define LSU_TIMEOUT_EN to add the REQ/WAIT watchdog and timeout_err.
module lsu_ctrl
    import cpu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [3:0]        mem_byt_en,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] load_data,
    output logic              misalign_err,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
`ifdef LSU_TIMEOUT_EN
    output logic              timeout_err,
`endif
    input  logic [DATA_W-1:0] dmem_rdata
);

    if (DATA_W != 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("lsu_ctrl: DATA_W must be 32 and TIMEOUT_CYCLES at least 1");
    end

    t_lsu_state  state;
    logic [1:0]  offset_q;
    logic [3:0]  size_q;
    logic        sext_q;
    logic        start;
    logic        legal;
    logic        launch;
    logic        tmo_hit;
    logic [31:0] aligned;

    assign start  = (state == LSU_IDLE) && (mem_rd_en || mem_wr_en) && (mem_byt_en != 4'b0000);
    assign legal  = lsu_aligned(mem_byt_en, addr[1:0]);
    assign launch = start && legal;

    // The launch cycle stalls combinationally so the PC never advances past
    // an access that is about to start.
    assign stall    = launch || (state == LSU_REQ) || (state == LSU_WAIT);
    assign done     = (state == LSU_DONE);
    assign dmem_req = (state == LSU_REQ);

    lsu_load_align u_load_align (
        .rdata    (dmem_rdata),
        .offset   (offset_q),
        .be       (size_q),
        .sign_ext (sext_q),
        .data     (aligned)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             busy;

    assign busy    = (state == LSU_REQ) || (state == LSU_WAIT);
    // A completing handshake in the limit cycle takes priority over the watchdog.
    assign tmo_hit = busy && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1))
                     && !((state == LSU_REQ) && dmem_gnt)
                     && !((state == LSU_WAIT) && dmem_rvalid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo_hit;
            tmo_cnt     <= busy ? tmo_cnt + 1'b1 : '0;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LSU_IDLE;
            misalign_err <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= '0;
            dmem_wdata   <= '0;
            load_data    <= '0;
            offset_q     <= '0;
            size_q       <= '0;
            sext_q       <= 1'b0;
        end else begin
            misalign_err <= start && !legal;
            case (state)
                LSU_IDLE: begin
                    if (launch) begin
                        dmem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        dmem_be    <= mem_byt_en << addr[1:0];
                        dmem_wdata <= wdata << {addr[1:0], 3'b000};
                        dmem_we    <= mem_wr_en;
                        offset_q   <= addr[1:0];
                        size_q     <= mem_byt_en;
                        sext_q     <= sign_ext;
                        state      <= LSU_REQ;
                    end
                end
                LSU_REQ: begin
                    if (dmem_gnt) begin
                        state <= dmem_we ? LSU_DONE : LSU_WAIT;
                    end else if (tmo_hit) begin
                        if (!dmem_we) load_data <= '0;
                        state <= LSU_DONE;
                    end
                end
                LSU_WAIT: begin
                    if (dmem_rvalid) begin
                        load_data <= aligned;
                        state     <= LSU_DONE;
                    end else if (tmo_hit) begin
                        load_data <= '0;
                        state     <= LSU_DONE;
                    end
                end
                default: state <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized
// accesses checked against a byte-level reference model.
module tb_lsu_ctrl;
    import cpu_pkg::*;

`ifdef LSU_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_rd_en = 1'b0, mem_wr_en = 1'b0, sign_ext = 1'b0;
    logic [3:0]  mem_byt_en = 4'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        stall, done, misalign_err, dmem_req, dmem_we;
    logic [31:0] load_data, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
`ifdef LSU_TIMEOUT_EN
    logic        timeout_err;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [31:0] model_ld = '0;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_byt_en   (mem_byt_en),
        .sign_ext     (sign_ext),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .done         (done),
        .load_data    (load_data),
        .misalign_err (misalign_err),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_gnt     (dmem_gnt),
        .dmem_rvalid  (dmem_rvalid),
`ifdef LSU_TIMEOUT_EN
        .timeout_err  (timeout_err),
`endif
        .dmem_rdata   (dmem_rdata)
    );

    typedef struct {
        int          stalls;
        logic        req_ever;
        logic        unstable;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic        done_seen;
        logic        done_after;
        logic [31:0] ld;
        logic        mis;
        logic        mis_after;
        logic        tmo;
    } res_t;

    // Reference model: sizes in bytes, legality by modulo, loads built byte by byte.
    function automatic int size_of(input logic [3:0] be);
        case (be)
            4'b0001: return 1;
            4'b0011: return 2;
            4'b1111: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic ref_legal(input logic [3:0] be, input logic [31:0] a);
        int n = size_of(be);
        return (n != 0) && ((int'(a[1:0]) % n) == 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                             input logic [3:0] be, input logic sx);
        int n = size_of(be);
        int off = int'(a[1:0]);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v |= 32'(rd[8*(off+i) +: 8]) << (8*i);
        if (sx && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8*n);
        return v;
    endfunction

    // Acts as both the stalled core and the memory. gd = REQ cycles before gnt,
    // rvd = WAIT cycles before rvalid; noise fires stray rvalids during REQ.
    task automatic run_access(input logic wr, input logic [3:0] be, input logic sx,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int gd, input int rvd, input logic [31:0] rd,
                              input logic noise, output res_t r);
        int   reqc = 0, waitc = 0;
        logic gnt_given = 1'b0, rv_given = 1'b0;
        r = '{default: 0};
        mem_rd_en = ~wr; mem_wr_en = wr; mem_byt_en = be;
        sign_ext = sx; addr = a; wdata = wd;
        for (int cyc = 0; cyc < 400; cyc++) begin
            #1;
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
            if (stall) r.stalls++;
`ifdef LSU_TIMEOUT_EN
            if (timeout_err) r.tmo = 1'b1;
`endif
            if (done) begin
                r.done_seen = 1'b1; r.ld = load_data;
                mem_rd_en = 1'b0; mem_wr_en = 1'b0;
                @(negedge clk); #1;
                r.done_after = done;
                return;
            end
            if (cyc == 0 && !stall) begin
                @(negedge clk);
                mem_rd_en = 1'b0; mem_wr_en = 1'b0;
                #1;
                r.mis = misalign_err; r.req_ever |= dmem_req;
                @(negedge clk); #1;
                r.mis_after = misalign_err;
                return;
            end
            if (dmem_req) begin
                if (!r.req_ever) begin
                    r.req_ever = 1'b1; r.addr = dmem_addr; r.be = dmem_be;
                    r.wdata = dmem_wdata; r.we = dmem_we;
                end else if (dmem_addr !== r.addr || dmem_be !== r.be ||
                             dmem_wdata !== r.wdata || dmem_we !== r.we) begin
                    r.unstable = 1'b1;
                end
                if (reqc == gd) begin
                    dmem_gnt = 1'b1; gnt_given = 1'b1;
                end else if (noise) begin
                    dmem_rvalid = 1'b1; dmem_rdata = ~rd;
                end
                reqc++;
            end else if (gnt_given && !wr && !rv_given) begin
                if (waitc == rvd) begin
                    dmem_rvalid = 1'b1; dmem_rdata = rd; rv_given = 1'b1;
                end
                waitc++;
            end
            @(negedge clk);
        end
        mem_rd_en = 1'b0; mem_wr_en = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_cnt++;
        if ({stall, done, misalign_err, dmem_req, dmem_we} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected 00000", {stall, done, misalign_err, dmem_req, dmem_we});
        else pass_cnt++;
        chk_cnt++;
        if ({load_data, dmem_addr, dmem_be, dmem_wdata} !== '0)
            $display("FAIL reset_data: got ld=%h addr=%h be=%b wd=%h expected all zero",
                     load_data, dmem_addr, dmem_be, dmem_wdata);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word_store();
        res_t r;
        run_access(1'b1, BE_WORD, 1'b0, 32'h104, 32'hDEADBEEF, 2, 0, '0, 1'b0, r);
        chk_cnt++;
        if (r.be !== 4'b1111 || r.addr !== 32'h104 || r.we !== 1'b1 || r.wdata !== 32'hDEADBEEF)
            $display("FAIL word_store_port: got be=%b addr=%h we=%b wd=%h expected be=1111 addr=00000104 we=1 wd=deadbeef",
                     r.be, r.addr, r.we, r.wdata);
        else pass_cnt++;
        chk_cnt++;
        if (r.stalls !== 4 || !r.done_seen || r.done_after !== 1'b0 || r.unstable)
            $display("FAIL word_store_timing: got stalls=%0d done=%b done_after=%b unstable=%b expected 4 1 0 0",
                     r.stalls, r.done_seen, r.done_after, r.unstable);
        else pass_cnt++;
    endtask

    task automatic test_byte_store();
        res_t r;
        run_access(1'b1, BE_BYTE, 1'b0, 32'h103, 32'h000000AB, 0, 0, '0, 1'b0, r);
        chk_cnt++;
        if (r.be !== 4'b1000 || r.addr !== 32'h100 || r.wdata !== 32'hAB000000)
            $display("FAIL byte_store_port: got be=%b addr=%h wd=%h expected be=1000 addr=00000100 wd=ab000000",
                     r.be, r.addr, r.wdata);
        else pass_cnt++;
        chk_cnt++;
        if (r.stalls !== 2 || !r.done_seen)
            $display("FAIL byte_store_latency: got stalls=%0d done=%b expected 2 1", r.stalls, r.done_seen);
        else pass_cnt++;
    endtask

    task automatic test_half_load();
        res_t r;
        run_access(1'b0, BE_HALF, 1'b1, 32'h202, '0, 0, 0, 32'h8001_1234, 1'b0, r);
        chk_cnt++;
        if (r.ld !== 32'hFFFF8001 || r.stalls !== 3 || r.be !== 4'b1100 || r.we !== 1'b0)
            $display("FAIL half_load_signed: got ld=%h stalls=%0d be=%b we=%b expected ffff8001 3 1100 0",
                     r.ld, r.stalls, r.be, r.we);
        else pass_cnt++;
        run_access(1'b0, BE_HALF, 1'b0, 32'h202, '0, 1, 2, 32'h8001_1234, 1'b1, r);
        chk_cnt++;
        if (r.ld !== 32'h00008001 || r.stalls !== 6)
            $display("FAIL half_load_unsigned: got ld=%h stalls=%0d expected 00008001 6", r.ld, r.stalls);
        else pass_cnt++;
        model_ld = 32'h00008001;
    endtask

    task automatic test_misalign();
        res_t r;
        run_access(1'b0, BE_WORD, 1'b0, 32'h101, '0, 0, 0, '0, 1'b0, r);
        chk_cnt++;
        if (r.mis !== 1'b1 || r.mis_after !== 1'b0 || r.req_ever || r.stalls !== 0)
            $display("FAIL misalign_word: got mis=%b after=%b req=%b stalls=%0d expected 1 0 0 0",
                     r.mis, r.mis_after, r.req_ever, r.stalls);
        else pass_cnt++;
        run_access(1'b1, 4'b0000, 1'b0, 32'h101, '0, 0, 0, '0, 1'b0, r);
        chk_cnt++;
        if (r.mis !== 1'b0 || r.req_ever || r.stalls !== 0)
            $display("FAIL zero_be_ignored: got mis=%b req=%b stalls=%0d expected 0 0 0",
                     r.mis, r.req_ever, r.stalls);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        res_t r;
        mem_rd_en = 1'b1; mem_byt_en = BE_WORD; addr = 32'h40; sign_ext = 1'b0;
        @(negedge clk); #1;
        dmem_gnt = dmem_req;
        @(negedge clk); #1;
        dmem_gnt = 1'b0;
        chk_cnt++;
        if (stall !== 1'b1 || dmem_req !== 1'b0)
            $display("FAIL reset_mid_wait: got stall=%b req=%b expected 1 0", stall, dmem_req);
        else pass_cnt++;
        mem_rd_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (stall !== 1'b0 || dmem_req !== 1'b0 || load_data !== '0)
            $display("FAIL reset_mid_async: got stall=%b req=%b ld=%h expected 0 0 0", stall, dmem_req, load_data);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        #1;
        chk_cnt++;
        if (done !== 1'b0 || stall !== 1'b0 || dmem_req !== 1'b0 || load_data !== '0)
            $display("FAIL reset_mid_stray_rvalid: got done=%b stall=%b req=%b ld=%h expected 0 0 0 0",
                     done, stall, dmem_req, load_data);
        else pass_cnt++;
        @(negedge clk);
        run_access(1'b0, BE_WORD, 1'b0, 32'h40, '0, 0, 1, 32'hCAFE_F00D, 1'b0, r);
        chk_cnt++;
        if (r.ld !== 32'hCAFEF00D || r.stalls !== 4)
            $display("FAIL reset_mid_next_load: got ld=%h stalls=%0d expected cafef00d 4", r.ld, r.stalls);
        else pass_cnt++;
        model_ld = 32'hCAFEF00D;
    endtask

    task automatic test_random();
        res_t        r;
        logic [3:0]  sizes [4] = '{BE_BYTE, BE_HALF, BE_WORD, 4'b0110};
        for (int k = 0; k < 40; k++) begin
            logic        wr = 1'($urandom);
            logic        sx = 1'($urandom);
            logic [3:0]  be = sizes[($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2)];
            logic [31:0] a  = $urandom & 32'h0000_FFFF;
            logic [31:0] wd = $urandom;
            logic [31:0] rd = $urandom;
            int          gd = $urandom_range(0, 3);
            int          rvd = $urandom_range(0, 3);
            int          n  = size_of(be);
            if (n != 0 && $urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
            if (!wr) wd = '0;
            run_access(wr, be, sx, a, wd, gd, rvd, rd, 1'($urandom), r);
            if (!ref_legal(be, a)) begin
                chk_cnt++;
                if (r.mis !== 1'b1 || r.req_ever || r.stalls !== 0)
                    $display("FAIL rand_misalign[%0d]: be=%b a=%h got mis=%b req=%b stalls=%0d expected 1 0 0",
                             k, be, a, r.mis, r.req_ever, r.stalls);
                else pass_cnt++;
            end else begin
                logic [31:0] exp_wd = wd << (8 * a[1:0]);
                logic [3:0]  exp_be = be << a[1:0];
                int          exp_st = wr ? 2 + gd : 3 + gd + rvd;
                chk_cnt++;
                if (r.addr !== (a & ~32'd3) || r.be !== exp_be || r.we !== wr ||
                    (wr && r.wdata !== exp_wd) || r.unstable)
                    $display("FAIL rand_port[%0d]: got addr=%h be=%b we=%b wd=%h unstable=%b expected %h %b %b %h 0",
                             k, r.addr, r.be, r.we, r.wdata, r.unstable, a & ~32'd3, exp_be, wr, exp_wd);
                else pass_cnt++;
                if (!wr) model_ld = ref_load(rd, a, be, sx);
                chk_cnt++;
                if (r.ld !== model_ld || r.stalls !== exp_st || !r.done_seen || r.done_after)
                    $display("FAIL rand_result[%0d]: got ld=%h stalls=%0d done=%b/%b expected %h %0d 1/0",
                             k, r.ld, r.stalls, r.done_seen, r.done_after, model_ld, exp_st);
                else pass_cnt++;
            end
        end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        res_t r;
        run_access(1'b1, BE_WORD, 1'b0, 32'h80, 32'h1, 1000, 0, '0, 1'b0, r);
        chk_cnt++;
        if (r.tmo !== 1'b1 || !r.done_seen || r.stalls !== 9)
            $display("FAIL timeout_store: got tmo=%b done=%b stalls=%0d expected 1 1 9", r.tmo, r.done_seen, r.stalls);
        else pass_cnt++;
        run_access(1'b0, BE_WORD, 1'b0, 32'h80, '0, 0, 1000, 32'h5555_5555, 1'b0, r);
        chk_cnt++;
        if (r.tmo !== 1'b1 || r.ld !== '0 || r.stalls !== 9)
            $display("FAIL timeout_load: got tmo=%b ld=%h stalls=%0d expected 1 0 9", r.tmo, r.ld, r.stalls);
        else pass_cnt++;
        model_ld = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_word_store();
        test_byte_store();
        test_half_load();
        test_misalign();
        test_reset_mid();
        test_random();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
